// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM states and line-level constants for serial receivers
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/word_out_buf.sv
// rtl/word_out_buf.sv - single-entry valid/ready holding register with load, accept and overrun
module word_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  logic can_load;

  // An accept on the same edge frees the slot for the incoming word.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= load && !can_load;
      if (load && can_load) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - strobe-timed serial frame receiver feeding a valid/ready word buffer
// Optional even-parity bit and parity_err port enabled by SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SERIAL_WORD_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state, state_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             word_good;
  logic             frame_bad;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic             par_bit, par_bit_next;
  logic             par_bad;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      cnt       <= cnt_next;
      frame_err <= frame_bad;
`ifdef SERIAL_WORD_RX_PARITY_EN
      par_bit    <= par_bit_next;
      parity_err <= par_bad;
`endif
    end
  end

  always_comb begin
    state_next = state;
    shift_next = shift;
    cnt_next   = cnt;
    word_good  = 1'b0;
    frame_bad  = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
    par_bit_next = par_bit;
    par_bad      = 1'b0;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (sdi == START_BIT) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          // Counter selects the landing bit directly, so no shifting across the word.
          for (int i = 0; i < WIDTH; i++) begin
            if (i == (LSB_FIRST ? int'(cnt) : WIDTH - 1 - int'(cnt))) shift_next[i] = sdi;
          end
          cnt_next = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            state_next = PAR;
`else
            state_next = STOP;
`endif
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_EN
        PAR: begin
          par_bit_next = sdi;
          state_next   = STOP;
        end
`endif
        STOP: begin
          state_next = IDLE;
          if (sdi == STOP_BIT) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
            if ((^shift) ^ par_bit) par_bad = 1'b1;
            else word_good = 1'b1;
`else
            word_good = 1'b1;
`endif
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  word_out_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (word_good),
    .load_data(shift),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Serial-to-parallel frame receiver that feeds a 4-bit data register stage (D_IN side) with an assembled word plus valid/ready handshake.
- Frame format: start bit (0), WIDTH data bits, optional parity bit, stop bit (1). Idle line is high.
- Bit timing comes from an external sample strobe. The block contains no baud generator.

Parameters:
- WIDTH, 4, number of data bits per frame (1..16).
- LSB_FIRST, 1, 1 = first data bit received lands in bit 0; 0 = first bit lands in bit WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- bit_en  in  1  one-cycle sample strobe; sdi is sampled only when bit_en=1
- sdi  in  1  serial data input, already synchronised to clk
- out_data  out  WIDTH  assembled word, held stable while out_valid=1
- out_valid  out  1  word available to downstream stage
- out_ready  in  1  downstream accepts the word when out_valid&out_ready at a rising edge
- busy  out  1  1 while the FSM is in any state other than IDLE
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  one-cycle pulse: completed word dropped because the buffer was full

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; shift register, bit counter and out_data cleared to 0; out_valid, busy, frame_err and overrun forced to 0.
- FSM states: IDLE, DATA, PAR, STOP. All transitions occur only on cycles with bit_en=1.
- IDLE:
  - sdi=0 -> DATA, bit counter cleared.
  - sdi=1 -> stay in IDLE.
- DATA:
  - Each strobe shifts sdi into the shift register (direction set by LSB_FIRST) and increments the counter.
  - After the WIDTH-th bit -> PAR if the parity feature is compiled in, otherwise -> STOP.
- PAR: sample the parity bit -> STOP.
- STOP, sdi=1 (good frame):
  - If the buffer is free (out_valid=0), or is being emptied this same cycle (out_valid&out_ready=1): load out_data and set out_valid=1 on the same edge.
  - Otherwise: drop the word, out_data unchanged, pulse overrun for one cycle.
  - In both cases -> IDLE.
- STOP, sdi=0: pulse frame_err, discard the word, -> IDLE. No re-sync hunt; IDLE waits for the next 0.
- Latency: out_valid rises on the clk edge of the stop-bit strobe, i.e. one cycle after that strobe is presented.
- Handshake:
  - out_valid clears on accept unless a new word loads on the same edge; in that case it stays 1 with the new data.
  - out_data never changes while out_valid=1 and no accept occurs.
- Strobe gaps: bit_en=0 cycles hold all state, any number of them, including inside a frame.
- Reset mid-frame: the partial word is discarded. A word already held in the buffer is also lost, since out_valid=0 after reset.
- Counter is $clog2(WIDTH+1) bits wide and never wraps within a frame.

Optional Feature:
- Macro: SERIAL_WORD_RX_PARITY_EN.
- Defined:
  - PAR state and parity_err output port (1 bit) exist.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - On mismatch at the good stop bit: pulse parity_err and drop the word (no load, no overrun).
  - parity_err resets to 0.
- Undefined: no PAR state, no parity_err port, frame length is WIDTH+2 bits.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, DATA, PAR, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One natural sub-module: word_out_buf, the single-entry valid/ready holding register with load/accept/overrun logic. It is reusable by sibling stages.

Test Plan:
- Basic frame: WIDTH=4, LSB_FIRST=1, bits 0,0,1,0,1,1 on consecutive strobes, out_ready=1 -> out_data=4'hA, out_valid high exactly 1 cycle, busy low afterwards.
- MSB-first: LSB_FIRST=0, same bit stream -> out_data=4'h5.
- Backpressure: out_ready=0, send 4'h3 then 4'hC -> out_data stays 4'h3, overrun pulses once at the second stop. Then raise out_ready -> out_valid drops the next cycle.
- Accept and load on the same edge: out_valid=1 holding 4'h3; assert out_ready in the cycle of the second frame's stop strobe -> out_data=4'hC, out_valid stays 1, no overrun.
- Framing error: stop bit sampled as 0 -> frame_err 1-cycle pulse, out_valid unchanged. A following good 4'h9 frame is received correctly.
- Async reset mid-DATA with out_valid=1 -> all outputs 0 immediately, no clock required. With the parity macro defined: bad parity on 4'h7 -> parity_err pulse, word not loaded.
